// File: rtl/cpu_controller_pkg.sv
// rtl/cpu_controller_pkg.sv - shared types and encodings for the simple-CPU controller
//
// Purpose: FSM state enum, instruction opcode/op codes, ALU op, shift and
//          writeback-select encodings used by the controller and its decoder.
// Ports:   none (package).
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_WR_IMM = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_RD  = 3'd5
    } state_t;

    // IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // IR[12:11] under OPC_MOV
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    // IR[12:11] under OPC_ALU, also the alu_op encoding
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Shifter control
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    // Writeback source
    localparam logic WB_C   = 1'b0;
    localparam logic WB_IMM = 1'b1;

endpackage

// File: rtl/cpu_controller_decode.sv
// rtl/cpu_controller_decode.sv - combinational instruction-register decoder
//
// Purpose: split the IR into register fields, produce the always-on decodes
//          (sximm8, shift_op, alu_op) and classify the instruction.
// Ports:   ir        in   16      instruction register contents
//          rn/rd/rm  out  3       register fields
//          shift_op  out  2       shifter control (forced to none for MOV-imm)
//          alu_op    out  2       ALU op (op field for ALU opcode, else ADD)
//          sximm8    out  DATA_W  sign-extended IR[7:0]
//          mov_imm, mov_reg, alu_wr (ADD/AND), cmp, mvn, illegal  out 1  class
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       ir,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [2:0]        rm,
    output logic [1:0]        shift_op,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] sximm8,
    output logic              mov_imm,
    output logic              mov_reg,
    output logic              alu_wr,
    output logic              cmp,
    output logic              mvn,
    output logic              illegal
);

    logic [2:0] opcode;
    logic [1:0] op;
    logic       is_mov;
    logic       is_alu;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    assign is_mov = (opcode == OPC_MOV);
    assign is_alu = (opcode == OPC_ALU);

    assign mov_imm = is_mov && (op == OP_MOV_IMM);
    assign mov_reg = is_mov && (op == OP_MOV_REG);
    assign alu_wr  = is_alu && ((op == ALU_ADD) || (op == ALU_AND));
    assign cmp     = is_alu && (op == ALU_CMP);
    assign mvn     = is_alu && (op == ALU_MVN);
    assign illegal = !(mov_imm || mov_reg || alu_wr || cmp || mvn);

    // MOV-imm has no shifter use; its sh bits belong to the immediate.
    assign shift_op = mov_imm ? SH_NONE : ir[4:3];
    // MOV-reg passes B through the ALU with the ADD encoding against A=0.
    assign alu_op   = is_alu ? op : ALU_ADD;

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register and control FSM for the simple CPU
//
// Purpose: holds the IR, sequences register file / A / B / C / status loads
//          for MOV-imm, MOV-reg, ADD, CMP, AND, MVN and owns the waiting
//          handshake. All datapath controls depend only on registered state.
// Ports:   clk, rst (async, active-high)
//          load, start, instr[15:0]                     from CPU top
//          waiting, done, illegal                       handshake / status
//          r_addr, w_addr, w_en, wb_sel                 register file
//          en_A, en_B, en_C, en_status, sel_A           pipeline registers
//          shift_op, alu_op, sximm8[DATA_W-1:0]         shifter / ALU / immediate
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              start,
    input  logic [15:0]       instr,
    output logic              waiting,
    output logic              done,
    output logic              illegal,
    output logic [2:0]        r_addr,
    output logic [2:0]        w_addr,
    output logic              w_en,
    output logic              wb_sel,
    output logic              en_A,
    output logic              en_B,
    output logic              en_C,
    output logic              en_status,
    output logic              sel_A,
    output logic [1:0]        shift_op,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] sximm8
);

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;
    logic        done_q;
    logic        illegal_q;

    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_alu_wr;
    logic        is_cmp;
    logic        is_mvn;
    logic        is_illegal;

    instr_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .ir       (ir),
        .rn       (rn),
        .rd       (rd),
        .rm       (rm),
        .shift_op (shift_op),
        .alu_op   (alu_op),
        .sximm8   (sximm8),
        .mov_imm  (is_mov_imm),
        .mov_reg  (is_mov_reg),
        .alu_wr   (is_alu_wr),
        .cmp      (is_cmp),
        .mvn      (is_mvn),
        .illegal  (is_illegal)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // IR only updates while idle and not starting, so it stays stable for
    // the whole instruction and a same-cycle load+start runs the old IR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if ((state == S_WAIT) && load && !start) begin
            ir <= instr;
        end
    end

    // Every state that flags done/illegal returns to WAIT on the next edge,
    // so the registered flag lines up with the first WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= (state == S_WR_IMM) || (state == S_WR_RD) ||
                         ((state == S_EXEC) && is_cmp);
            illegal_q <= (state == S_WAIT) && start && is_illegal;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = S_WAIT;
        case (state)
            S_WAIT: begin
                next_state = S_WAIT;
                if (start) begin
                    if (is_mov_imm) begin
                        next_state = S_WR_IMM;
                    end else if (is_alu_wr || is_cmp) begin
                        next_state = S_LOAD_A;
                    end else if (is_mov_reg || is_mvn) begin
                        next_state = S_LOAD_B;
                    end
                end
            end
            S_WR_IMM: next_state = S_WAIT;
            S_LOAD_A: next_state = S_LOAD_B;
            S_LOAD_B: next_state = S_EXEC;
            S_EXEC:   next_state = is_cmp ? S_WAIT : S_WR_RD;
            S_WR_RD:  next_state = S_WAIT;
            default:  next_state = S_WAIT;
        endcase
    end

    // Moore outputs
    always_comb begin
        waiting   = 1'b0;
        r_addr    = 3'd0;
        w_addr    = 3'd0;
        w_en      = 1'b0;
        wb_sel    = WB_C;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        sel_A     = 1'b0;
        case (state)
            S_WAIT: begin
                waiting = 1'b1;
            end
            S_WR_IMM: begin
                w_en   = 1'b1;
                w_addr = rn;
                wb_sel = WB_IMM;
            end
            S_LOAD_A: begin
                r_addr = rn;
                en_A   = 1'b1;
            end
            S_LOAD_B: begin
                r_addr = rm;
                en_B   = 1'b1;
            end
            S_EXEC: begin
                en_C      = 1'b1;
                en_status = is_cmp;
                sel_A     = is_mov_reg || is_mvn;
            end
            S_WR_RD: begin
                w_en   = 1'b1;
                w_addr = rd;
                wb_sel = WB_C;
                // Held so a C register still being settled sees the same A input.
                sel_A  = is_mov_reg || is_mvn;
            end
            default: begin
                waiting = 1'b0;
            end
        endcase
    end

    assign done    = done_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller
module tb_cpu_controller;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        waiting, done, illegal, w_en, wb_sel;
    logic        en_A, en_B, en_C, en_status, sel_A;
    logic [2:0]  r_addr, w_addr;
    logic [1:0]  shift_op, alu_op;
    logic [15:0] sximm8;

    cpu_controller #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .instr(instr),
        .waiting(waiting), .done(done), .illegal(illegal),
        .r_addr(r_addr), .w_addr(w_addr), .w_en(w_en), .wb_sel(wb_sel),
        .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
        .sel_A(sel_A), .shift_op(shift_op), .alu_op(alu_op), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        waiting;
        logic        done;
        logic        illegal;
        logic [2:0]  r_addr;
        logic [2:0]  w_addr;
        logic        w_en;
        logic        wb_sel;
        logic        en_a;
        logic        en_b;
        logic        en_c;
        logic        en_status;
        logic        sel_a;
        logic [1:0]  shift_op;
        logic [1:0]  alu_op;
        logic [15:0] sximm8;
    } outs_t;

    typedef struct {
        logic [15:0] instr;
        int          busy;
        bit          wrote;
        logic [15:0] sx;
    } vec_t;

    localparam int C_MOVI = 0, C_MOVR = 1, C_ADD = 2, C_CMP = 3, C_AND = 4, C_MVN = 5, C_ILL = 6;

    int    checks = 0;
    int    failures = 0;
    outs_t exp_q[$];

    task automatic check_o(input string nm, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (w_en=%b/%b waiting=%b/%b done=%b/%b)",
                     nm, got, exp, got.w_en, exp.w_en, got.waiting, exp.waiting, got.done, exp.done);
        end
    endtask

    task automatic check_i(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.waiting = waiting;   o.done = done;       o.illegal = illegal;
        o.r_addr = r_addr;     o.w_addr = w_addr;   o.w_en = w_en;
        o.wb_sel = wb_sel;     o.en_a = en_A;       o.en_b = en_B;
        o.en_c = en_C;         o.en_status = en_status;
        o.sel_a = sel_A;       o.shift_op = shift_op;
        o.alu_op = alu_op;     o.sximm8 = sximm8;
        return o;
    endfunction

    function automatic int classify(input logic [15:0] w);
        case (w[15:11])
            5'b110_10: return C_MOVI;
            5'b110_00: return C_MOVR;
            5'b101_00: return C_ADD;
            5'b101_01: return C_CMP;
            5'b101_10: return C_AND;
            5'b101_11: return C_MVN;
            default:   return C_ILL;
        endcase
    endfunction

    // Decodes visible in every cycle regardless of state.
    function automatic outs_t base_rec(input logic [15:0] w);
        outs_t o = '0;
        o.shift_op = (classify(w) == C_MOVI) ? 2'b00 : w[4:3];
        o.alu_op   = (w[15:13] == 3'b101) ? w[12:11] : 2'b00;
        o.sximm8   = {{8{w[7]}}, w[7:0]};
        return o;
    endfunction

    function automatic outs_t idle_rec(input logic [15:0] w);
        outs_t o = base_rec(w);
        o.waiting = 1'b1;
        return o;
    endfunction

    // Per-cycle expected outputs after the start edge, ending with the WAIT
    // cycle that carries done (or illegal).
    function automatic void build_expect(input logic [15:0] w);
        int    cls = classify(w);
        outs_t b = base_rec(w);
        outs_t la = b, lb = b, ex = b, wr = b, wi = b, fin = b, ill = b;
        la.r_addr = w[10:8]; la.en_a = 1'b1;
        lb.r_addr = w[2:0];  lb.en_b = 1'b1;
        ex.en_c = 1'b1;
        ex.en_status = (cls == C_CMP);
        ex.sel_a = (cls == C_MOVR) || (cls == C_MVN);
        wr.w_en = 1'b1; wr.w_addr = w[7:5]; wr.sel_a = ex.sel_a;
        wi.w_en = 1'b1; wi.w_addr = w[10:8]; wi.wb_sel = 1'b1;
        fin.waiting = 1'b1; fin.done = 1'b1;
        ill.waiting = 1'b1; ill.illegal = 1'b1;
        exp_q.delete();
        case (cls)
            C_MOVI:       begin exp_q.push_back(wi); exp_q.push_back(fin); end
            C_ADD, C_AND: begin exp_q.push_back(la); exp_q.push_back(lb); exp_q.push_back(ex);
                                exp_q.push_back(wr); exp_q.push_back(fin); end
            C_CMP:        begin exp_q.push_back(la); exp_q.push_back(lb); exp_q.push_back(ex);
                                exp_q.push_back(fin); end
            C_MOVR, C_MVN:begin exp_q.push_back(lb); exp_q.push_back(ex); exp_q.push_back(wr);
                                exp_q.push_back(fin); end
            default:      exp_q.push_back(ill);
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_instr(input logic [15:0] w, input bit noise,
                             output int busy, output bit wrote, output logic [15:0] sx);
        outs_t got;
        build_expect(w);
        load = 1'b1; start = 1'b0; instr = w;
        @(negedge clk);
        load = 1'b0; start = 1'b1; instr = 16'($urandom);
        got = sample();
        sx = got.sximm8;
        check_o("pre_start", got, idle_rec(w));
        @(negedge clk);
        start = 1'b0;
        busy = 0;
        wrote = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = sample();
            if (!got.waiting) busy++;
            if (got.w_en) wrote = 1'b1;
            check_o($sformatf("step%0d_%h", i, w), got, exp_q[i]);
            if (noise && (i < exp_q.size() - 1)) begin
                load = 1'($urandom); start = 1'($urandom); instr = 16'($urandom);
            end else begin
                load = 1'b0; start = 1'b0;
            end
            @(negedge clk);
        end
        check_o("after_done", sample(), idle_rec(w));
    endtask

    vec_t        tbl[7];
    int          busy;
    bit          wrote;
    logic [15:0] sx;
    logic [15:0] w;

    initial begin
        tbl[0] = '{instr: 16'hD7FD, busy: 1, wrote: 1'b1, sx: 16'hFFFD};
        tbl[1] = '{instr: 16'hA049, busy: 4, wrote: 1'b1, sx: 16'h0049};
        tbl[2] = '{instr: 16'hAB01, busy: 3, wrote: 1'b0, sx: 16'h0001};
        tbl[3] = '{instr: 16'hB813, busy: 3, wrote: 1'b1, sx: 16'h0013};
        tbl[4] = '{instr: 16'hC0A2, busy: 3, wrote: 1'b1, sx: 16'hFFA2};
        tbl[5] = '{instr: 16'hB5E0, busy: 4, wrote: 1'b1, sx: 16'hFFE0};
        tbl[6] = '{instr: 16'hE000, busy: 0, wrote: 1'b0, sx: 16'h0000};

        // Reset, then start with IR=0 (illegal)
        #2 rst = 1'b1;
        @(negedge clk);
        check_o("reset", sample(), idle_rec(16'h0000));
        rst = 1'b0;
        @(negedge clk);
        check_o("post_reset", sample(), idle_rec(16'h0000));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            outs_t e = idle_rec(16'h0000);
            e.illegal = 1'b1;
            check_o("illegal_pulse", sample(), e);
        end
        @(negedge clk);
        check_o("illegal_clear", sample(), idle_rec(16'h0000));

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i].instr, 1'b0, busy, wrote, sx);
            check_i($sformatf("busy_%h", tbl[i].instr), busy, tbl[i].busy);
            check_i($sformatf("wrote_%h", tbl[i].instr), int'(wrote), int'(tbl[i].wrote));
            check_i($sformatf("sximm8_%h", tbl[i].instr), int'(sx), int'(tbl[i].sx));
        end

        // load together with start: held IR (MOV R7,#-3) runs, IR unchanged
        run_instr(16'hD7FD, 1'b0, busy, wrote, sx);
        build_expect(16'hD7FD);
        load = 1'b1; start = 1'b1; instr = 16'hA049;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check_o("ldst_exec", sample(), exp_q[0]);
        @(negedge clk);
        check_o("ldst_done", sample(), exp_q[1]);
        @(negedge clk);
        check_o("ldst_ir_kept", sample(), idle_rec(16'hD7FD));

        // load during LOAD_B ignored, async reset in EXEC aborts the write
        build_expect(16'hA049);
        load = 1'b1; instr = 16'hA049;
        @(negedge clk);
        load = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_o("abort_load_a", sample(), exp_q[0]);
        @(negedge clk);
        check_o("abort_load_b", sample(), exp_q[1]);
        load = 1'b1; instr = 16'hD105;
        @(negedge clk);
        load = 1'b0;
        check_o("abort_exec_ir_stable", sample(), exp_q[2]);
        #2 rst = 1'b1;
        #1 check_o("abort_async_rst", sample(), idle_rec(16'h0000));
        @(negedge clk);
        check_o("abort_rst_hold", sample(), idle_rec(16'h0000));
        rst = 1'b0;
        @(negedge clk);
        check_o("abort_no_wr_rd", sample(), idle_rec(16'h0000));

        // Randomized instructions with load/start noise while busy
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    w = {3'b101, 13'($urandom)};
                2:       w = {3'b110, 13'($urandom)};
                default: w = 16'($urandom);
            endcase
            run_instr(w, 1'b1, busy, wrote, sx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction register plus control FSM that sequences the simple-CPU datapath (register file, A/B/C pipeline registers, shifter, ALU, ZNV status) for MOV-imm, MOV-reg, ADD, CMP, AND and MVN.
- Accepts load/start from the CPU top and owns the `waiting` handshake.
- Drives every datapath enable, select and address as registered Moore outputs.

Parameters:
- DATA_W, 16, datapath word width (sximm8 is sign-extended to this width).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  latch `instr` into the instruction register (IR).
- start  in  1  begin executing the instruction held in IR.
- instr  in  16  instruction word.
- waiting  out  1  1 = idle and ready for start.
- done  out  1  one-cycle pulse on return to WAIT after an executed instruction.
- illegal  out  1  one-cycle pulse when start is given with an undecodable IR.
- r_addr  out  3  register-file read address.
- w_addr  out  3  register-file write address.
- w_en  out  1  register-file write enable.
- wb_sel  out  1  writeback source: 0 = C register, 1 = sximm8.
- en_A  out  1  load enable for A. en_B  out  1  load enable for B. en_C  out  1  load enable for C.
- en_status  out  1  load enable for ZNV.
- sel_A  out  1  1 = ALU A input forced to zero.
- shift_op  out  2  shifter control.
- alu_op  out  2  ALU operation.
- sximm8  out  DATA_W  sign-extended IR[7:0].

Behaviour:
- IR fields:
  - opcode = IR[15:13]; op = IR[12:11]; Rn = IR[10:8]; Rd = IR[7:5]; sh = IR[4:3]; Rm = IR[2:0].
  - Legal encodings: 110/10 MOV-imm; 110/00 MOV-reg; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. Everything else is illegal.
- Continuous decodes, combinational from IR in every state:
  - sximm8 = sign-extended IR[7:0].
  - shift_op = sh, except MOV-imm drives 00.
  - alu_op = op for opcode 101; 00 for MOV-reg.
- States: WAIT, WR_IMM, LOAD_A, LOAD_B, EXEC, WR_RD.
- Outputs per state (any output not listed is 0):
  - WAIT: waiting=1.
  - WR_IMM: w_en=1, w_addr=Rn, wb_sel=1.
  - LOAD_A: r_addr=Rn, en_A=1.
  - LOAD_B: r_addr=Rm, en_B=1.
  - EXEC: en_C=1. en_status=1 only for CMP. sel_A=1 for MOV-reg and MVN.
  - WR_RD: w_en=1, w_addr=Rd, wb_sel=0. sel_A is held as in EXEC.
- Transitions from WAIT (start=1):
  - MOV-imm → WR_IMM.
  - ADD/CMP/AND → LOAD_A.
  - MOV-reg/MVN → LOAD_B.
  - Illegal → stay in WAIT and pulse illegal the next cycle.
- Remaining transitions:
  - LOAD_A → LOAD_B → EXEC.
  - EXEC → WR_RD, except CMP, which goes EXEC → WAIT.
  - WR_IMM → WAIT; WR_RD → WAIT.
- Busy cycles after the start edge: MOV-imm 1; MOV-reg/MVN 3; CMP 3; ADD/AND 4.
- done is 1 in the first WAIT cycle after WR_IMM, WR_RD, or EXEC of a CMP.
- Load rules:
  - load is honoured only in WAIT with start=0.
  - load with start in the same cycle: load is ignored; the already-held IR executes.
  - load while busy is ignored; IR stays stable for the whole instruction.
- start outside WAIT is ignored and not queued.
- Reset (asynchronous, any time including mid-instruction):
  - state=WAIT, IR=0, waiting=1.
  - done, illegal, w_en and all enables = 0.
  - No partial write completes.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum;
  - opcode/op localparams (MOV, ALU);
  - ALU op encodings (ADD, CMP, AND, MVN);
  - shift encodings;
  - wb_sel encodings.
- One combinational sub-module, instr_decode: IR → fields, sximm8, class (mov_imm, mov_reg, alu_wr, cmp, mvn, illegal).

Test Plan:
- Reset, then release rst → waiting=1, done=0, w_en=0; start with IR=0 → illegal pulses for 1 cycle, waiting stays 1.
- load 0xD7FD, start (MOV R7,#-3) → one cycle WR_IMM with w_en=1, w_addr=7, wb_sel=1, sximm8=0xFFFD; next cycle waiting=1, done=1.
- load 0xA049, start (ADD R2,R0,R1 LSL) → states in order:
  - LOAD_A: r_addr=0, en_A=1.
  - LOAD_B: r_addr=1, en_B=1, shift_op=01.
  - EXEC: en_C=1, alu_op=00.
  - WR_RD: w_addr=2, w_en=1.
  - Then waiting=1; 4 busy cycles.
- load 0xAB01, start (CMP R3,R1) → LOAD_A(r_addr=3), LOAD_B(r_addr=1), EXEC(en_status=1, alu_op=01); w_en never 1; done after 3 busy cycles.
- load 0xB813, start (MVN R0,R3 LSR) → LOAD_B(r_addr=3, shift_op=10), EXEC(sel_A=1, alu_op=11), WR_RD(w_addr=0); LOAD_A never entered.
- Start 0xA049, pulse load 0xD105 during LOAD_B, assert rst in EXEC:
  - IR unchanged through LOAD_B/EXEC.
  - On rst: immediate WAIT, w_en=0, no WR_RD cycle, IR reads 0.
